// File: rtl/tx_arbiter_if.sv
// Request/grant and TX-pin signals shared between the two requesters and tx_arbiter.
// The master side drives requests; the slave side is the arbiter.
interface tx_arbiter_if #(
    parameter int unsigned NSHIFT   = 2,
    parameter int unsigned CMD_BITS = 2,
    parameter int unsigned CNT_W    = 4
);
    logic                pf_cmd_valid;
    logic [CMD_BITS-1:0] pf_cmd;
    logic [NSHIFT-1:0]   pf_data;
    logic                sc_cmd_valid;
    logic [CMD_BITS-1:0] sc_cmd;
    logic [NSHIFT-1:0]   sc_data;
    logic                sc_reserve;
    logic                tx_stall;

    logic                pf_started;
    logic                sc_started;
    logic                pf_data_next;
    logic                sc_data_next;
    logic                tx_active;
    logic                tx_owner;
    logic [CNT_W-1:0]    tx_counter;
    logic                tx_done;
    logic [NSHIFT-1:0]   tx_pins;

    modport master (
        output pf_cmd_valid, pf_cmd, pf_data,
        output sc_cmd_valid, sc_cmd, sc_data, sc_reserve, tx_stall,
        input  pf_started, sc_started, pf_data_next, sc_data_next,
        input  tx_active, tx_owner, tx_counter, tx_done, tx_pins
    );

    modport slave (
        input  pf_cmd_valid, pf_cmd, pf_data,
        input  sc_cmd_valid, sc_cmd, sc_data, sc_reserve, tx_stall,
        output pf_started, sc_started, pf_data_next, sc_data_next,
        output tx_active, tx_owner, tx_counter, tx_done, tx_pins
    );
endinterface

// File: rtl/tx_arbiter.sv
// Shares one serial TX channel between prefetch and scheduler; frames are START, header, payload.
// Define TX_ARB_ROUND_ROBIN_EN to replace fixed scheduler priority with round-robin on contention.
module tx_arbiter #(
    parameter int unsigned NSHIFT         = 2,
    parameter int unsigned CMD_BITS       = 2,
    parameter int unsigned PAYLOAD_CYCLES = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    tx_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W      = $clog2(PAYLOAD_CYCLES) + 1;
    localparam int unsigned HDR_CYCLES = CMD_BITS / NSHIFT;
    localparam int unsigned HDR_W      = (HDR_CYCLES > 1) ? $clog2(HDR_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_CYCLES - 1);
    localparam logic [HDR_W-1:0] LAST_HDR = HDR_W'(HDR_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StStart, StHeader, StPayload} state_e;

    state_e              state_q, state_d;
    logic [CMD_BITS-1:0] hdr_q, hdr_d;
    logic [HDR_W-1:0]    hdr_cnt_q, hdr_cnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                owner_q, owner_d;
    logic [NSHIFT-1:0]   pins_q;

    logic                active;
    logic                done;
    logic                window;
    logic                sc_elig, pf_elig;
    logic                sc_wins;
    logic                grant_sc, grant_pf, grant;
    logic [NSHIFT-1:0]   pins_live, pins_out;

    assign active  = (state_q != StIdle);
    assign done    = (state_q == StPayload) && (cnt_q == LAST_CNT) && !bus.tx_stall;
    // Gating with rst_n keeps the started pulses low while reset is held.
    assign window  = rst_n && !bus.tx_stall && ((state_q == StIdle) || done);
    assign sc_elig = bus.sc_cmd_valid;
    assign pf_elig = bus.pf_cmd_valid && !bus.sc_reserve;

`ifdef TX_ARB_ROUND_ROBIN_EN
    // ptr_q = 1: scheduler preferred on contention; flips to the loser after each grant.
    logic ptr_q, ptr_d;

    assign sc_wins = sc_elig && (!pf_elig || ptr_q);

    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            ptr_d = grant_pf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign sc_wins = sc_elig;
`endif

    assign grant_sc = window && sc_wins;
    assign grant_pf = window && pf_elig && !sc_wins;
    assign grant    = grant_sc || grant_pf;

    always_comb begin
        pins_live = '0;
        unique case (state_q)
            StIdle:    pins_live = '0;
            StStart:   pins_live = '1;
            StHeader:  pins_live = hdr_q[CMD_BITS-1 -: NSHIFT];
            StPayload: pins_live = owner_q ? bus.sc_data : bus.pf_data;
            default:   pins_live = '0;
        endcase
    end

    // A stalled frame keeps driving whatever the pins showed on the last moving cycle.
    assign pins_out = (bus.tx_stall && active) ? pins_q : pins_live;

    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        hdr_cnt_d = hdr_cnt_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;

        if (!bus.tx_stall) begin
            unique case (state_q)
                StIdle: begin
                    if (grant) begin
                        state_d = StStart;
                    end
                end
                StStart: begin
                    state_d   = StHeader;
                    hdr_cnt_d = '0;
                end
                StHeader: begin
                    if (hdr_cnt_q == LAST_HDR) begin
                        state_d = StPayload;
                        cnt_d   = '0;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + HDR_W'(1);
                        hdr_d     = hdr_q << NSHIFT;
                    end
                end
                StPayload: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = grant ? StStart : StIdle;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (grant) begin
            hdr_d     = grant_sc ? bus.sc_cmd : bus.pf_cmd;
            hdr_cnt_d = '0;
            owner_d   = grant_sc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            hdr_q     <= '0;
            hdr_cnt_q <= '0;
            cnt_q     <= '0;
            owner_q   <= 1'b0;
            pins_q    <= '0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            hdr_cnt_q <= hdr_cnt_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            pins_q    <= pins_out;
        end
    end

    assign bus.pf_started   = grant_pf;
    assign bus.sc_started   = grant_sc;
    assign bus.pf_data_next = (state_q == StPayload) && !bus.tx_stall && !owner_q;
    assign bus.sc_data_next = (state_q == StPayload) && !bus.tx_stall && owner_q;
    assign bus.tx_active    = active;
    assign bus.tx_owner     = owner_q;
    assign bus.tx_counter   = (state_q == StPayload) ? cnt_q : '0;
    assign bus.tx_done      = done;
    assign bus.tx_pins      = pins_out;
endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: single frame, contention, reservation, stall, async reset.
module tb_tx_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    tx_arbiter_if #(.NSHIFT(2), .CMD_BITS(2), .CNT_W(4)) bus ();

    tx_arbiter #(.NSHIFT(2), .CMD_BITS(2), .PAYLOAD_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] pat(input bit owner, input int i);
        pat = 2'((i * 3) + int'(owner) + 1);
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_active"}, 32'(bus.tx_active), 0);
        check_eq({tag, "_pins"}, 32'(bus.tx_pins), 0);
        check_eq({tag, "_cnt"}, 32'(bus.tx_counter), 0);
    endtask

    // Runs from the START cycle through the last payload cycle of a frame.
    task automatic frame_body(input bit owner, input logic [1:0] cmd, input int stall_at,
                              input int stall_len, input int abort_at,
                              input bit exp_pf_next, input bit exp_sc_next);
        int         i;
        int         stalled;
        int         strobes;
        int         cycles;
        bit         stall;
        logic [1:0] p;
        logic [1:0] last;
        tick();
        if (owner) bus.sc_cmd_valid = 1'b0;
        else       bus.pf_cmd_valid = 1'b0;
        #1;
        check_eq("start_pins", 32'(bus.tx_pins), 3);
        check_eq("start_active", 32'(bus.tx_active), 1);
        check_eq("start_owner", 32'(bus.tx_owner), 32'(owner));
        check_eq("start_cnt", 32'(bus.tx_counter), 0);
        tick();
        #1;
        check_eq("hdr_pins", 32'(bus.tx_pins), 32'(cmd));
        check_eq("hdr_next", 32'(owner ? bus.sc_data_next : bus.pf_data_next), 0);
        last    = cmd;
        i       = 0;
        stalled = 0;
        strobes = 0;
        cycles  = 0;
        while (i < 8) begin
            tick();
            p            = pat(owner, i);
            bus.sc_data  = owner ? p : ~p;
            bus.pf_data  = owner ? ~p : p;
            stall        = (i == stall_at) && (stalled < stall_len);
            bus.tx_stall = stall;
            #1;
            cycles++;
            strobes += int'(owner ? bus.sc_data_next : bus.pf_data_next);
            check_eq("other_next", 32'(owner ? bus.pf_data_next : bus.sc_data_next), 0);
            if (stall) begin
                check_eq("stall_cnt", 32'(bus.tx_counter), 32'(i));
                check_eq("stall_pins", 32'(bus.tx_pins), 32'(last));
                check_eq("stall_done", 32'(bus.tx_done), 0);
                stalled++;
            end else begin
                check_eq("pay_pins", 32'(bus.tx_pins), 32'(p));
                check_eq("pay_cnt", 32'(bus.tx_counter), 32'(i));
                check_eq("pay_done", 32'(bus.tx_done), 32'(i == 7));
                if (i == 7) begin
                    check_eq("b2b_pf_started", 32'(bus.pf_started), 32'(exp_pf_next));
                    check_eq("b2b_sc_started", 32'(bus.sc_started), 32'(exp_sc_next));
                end
                last = p;
                if (i == abort_at) return;
                i++;
            end
        end
        check_eq("strobes", 32'(strobes), 8);
        check_eq("frame_cycles", 32'(cycles), 32'(8 + stall_len));
    endtask

    initial begin
        bit first;
        bit seen;
        n_cmp            = 0;
        n_err            = 0;
        rst_n            = 1'b0;
        bus.pf_cmd_valid = 1'b0;
        bus.pf_cmd       = '0;
        bus.pf_data      = '0;
        bus.sc_cmd_valid = 1'b0;
        bus.sc_cmd       = '0;
        bus.sc_data      = '0;
        bus.sc_reserve   = 1'b0;
        bus.tx_stall     = 1'b0;
        #3;
        check_idle("reset");
        check_eq("reset_owner", 32'(bus.tx_owner), 0);
        check_eq("reset_done", 32'(bus.tx_done), 0);
        tick();
        rst_n = 1'b1;

        // Single scheduler frame
        tick();
        bus.sc_cmd_valid = 1'b1;
        bus.sc_cmd       = 2'b10;
        #1;
        check_eq("single_sc_started", 32'(bus.sc_started), 1);
        check_eq("single_pf_started", 32'(bus.pf_started), 0);
        check_eq("single_grant_pins", 32'(bus.tx_pins), 0);
        frame_body(1'b1, 2'b10, -1, 0, -1, 1'b0, 1'b0);
        tick();
        #1;
        check_idle("single_end");

        // Contention; the loser follows back-to-back
`ifdef TX_ARB_ROUND_ROBIN_EN
        first = 1'b0;
`else
        first = 1'b1;
`endif
        tick();
        bus.pf_cmd_valid = 1'b1;
        bus.pf_cmd       = 2'b01;
        bus.sc_cmd_valid = 1'b1;
        bus.sc_cmd       = 2'b11;
        #1;
        check_eq("cont_sc_started", 32'(bus.sc_started), 32'(first));
        check_eq("cont_pf_started", 32'(bus.pf_started), 32'(!first));
        frame_body(first, first ? 2'b11 : 2'b01, -1, 0, -1, first, !first);
        frame_body(!first, first ? 2'b01 : 2'b11, -1, 0, -1, 1'b0, 1'b0);
        tick();
        #1;
        check_idle("cont_end");

        // Reservation blocks prefetch; release grants in the same cycle
        tick();
        bus.sc_reserve   = 1'b1;
        bus.pf_cmd_valid = 1'b1;
        bus.pf_cmd       = 2'b11;
        #1;
        seen = bus.pf_started;
        for (int k = 1; k < 20; k++) begin
            tick();
            #1;
            seen |= bus.pf_started;
        end
        check_eq("resv_blocked", 32'(seen), 0);
        tick();
        bus.sc_reserve = 1'b0;
        #1;
        check_eq("resv_release", 32'(bus.pf_started), 1);
        frame_body(1'b0, 2'b11, -1, 0, -1, 1'b0, 1'b0);
        tick();
        #1;
        check_idle("resv_end");

        // Stall in IDLE, then a payload stall
        tick();
        bus.tx_stall     = 1'b1;
        bus.sc_cmd_valid = 1'b1;
        bus.sc_cmd       = 2'b01;
        #1;
        check_eq("idle_stall_nogrant", 32'(bus.sc_started), 0);
        tick();
        bus.tx_stall = 1'b0;
        #1;
        check_eq("idle_stall_grant", 32'(bus.sc_started), 1);
        frame_body(1'b1, 2'b01, 4, 3, -1, 1'b0, 1'b0);
        tick();
        #1;
        check_idle("stall_end");

        // Async reset mid-payload
        tick();
        bus.sc_cmd_valid = 1'b1;
        bus.sc_cmd       = 2'b11;
        #1;
        check_eq("rst_pre_started", 32'(bus.sc_started), 1);
        frame_body(1'b1, 2'b11, -1, 0, 5, 1'b0, 1'b0);
        #2;
        rst_n            = 1'b0;
        bus.sc_cmd_valid = 1'b1;
        bus.sc_cmd       = 2'b10;
        #1;
        check_idle("async_rst");
        check_eq("async_rst_owner", 32'(bus.tx_owner), 0);
        check_eq("async_rst_next", 32'(bus.sc_data_next), 0);
        check_eq("async_rst_done", 32'(bus.tx_done), 0);
        check_eq("async_rst_started", 32'(bus.sc_started), 0);
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_started", 32'(bus.sc_started), 1);
        frame_body(1'b1, 2'b10, -1, 0, -1, 1'b0, 1'b0);
        tick();
        #1;
        check_idle("post_rst_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
